mem_responder: RTL

Memory-side responder for the PicoRV32 native memory interface driven by `cpu`. It accepts one request at a time on `mem_valid`, inserts a configurable number of wait states, and then commits byte-strobed writes or returns read data with a single-cycle `mem_ready` pulse. It sits between the CPU and a word-organised on-chip RAM, and serves both instruction fetch and load/store traffic.

---
 rtl/mem_responder_pkg.sv | 5 +
 rtl/mem_array.sv | 18 +
 rtl/mem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared FSM state type and constants for mem_responder.
package mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} resp_state_t;
  localparam logic [31:0] MEM_ERR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_array.sv
// mem_array: word-organised RAM with byte-lane write enables and one synchronous read port.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: PicoRV32 native-interface RAM responder with configurable wait states.
// Define MEM_BOUNDS_CHECK_EN to flag out-of-range accesses on mem_err and suppress them.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, wstrb_q, wstrb_d, cur_wstrb, we;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, fill_q, fill_d;
  logic [31:0] cur_addr, cur_wdata, off, ram_rdata;
  logic        ready_q, ready_d, sel_q, sel_d, err_q, err_d, ack, in_range;
  logic        unused_ok;
  // In IDLE the request is taken straight from the inputs so LATENCY=0 can commit on the accepting edge.
  assign cur_addr  = (state_q == IDLE) ? mem_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? mem_wdata : wdata_q;
  assign cur_wstrb = (state_q == IDLE) ? mem_wstrb : wstrb_q;
  assign off       = cur_addr - BASE_ADDR;
`ifdef MEM_BOUNDS_CHECK_EN
  assign in_range = ({1'b0, cur_addr} - {1'b0, BASE_ADDR}) < (33'(DEPTH_WORDS) << 2);
`else
  assign in_range = 1'b1;
`endif
  assign we        = (ack && in_range) ? cur_wstrb : 4'b0000;
  assign unused_ok = ^{mem_instr, off[31:AW+2], off[1:0]};
  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk   (clk),
    .we    (we),
    .addr  (off[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ready_d = 1'b0;
    sel_d   = sel_q;
    fill_d  = fill_q;
    err_d   = err_q;
    ack     = 1'b0;
    case (state_q)
      IDLE: if (mem_valid) begin
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        wstrb_d = mem_wstrb;
        if (LATENCY == 0) ack = 1'b1;
        else begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: if (!mem_valid) state_d = IDLE;
        else if (cnt_q == 4'd0) ack = 1'b1;
        else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
    // Read data comes from the RAM output register during ACK; writes and rejected reads use fill_q.
    if (ack) begin
      state_d = ACK;
      ready_d = 1'b1;
      sel_d   = ~|cur_wstrb & in_range;
      fill_d  = |cur_wstrb ? 32'h0 : MEM_ERR_RDATA;
      err_d   = err_q | ~in_range;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      sel_q   <= 1'b0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      sel_q   <= sel_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end
  assign mem_ready = ready_q;
  assign mem_rdata = sel_q ? ram_rdata : fill_q;
  assign mem_err   = err_q;
endmodule
